// File: rtl/mxint_block_packer.sv
// MXINT block packer: groups a serial stream of signed fixed-point elements
// into blocks, picks a shared exponent per block and emits normalised
// mantissas plus the exponent as one beat under valid/ready.
module mxint_block_packer #(
   parameter int unsigned IN_WIDTH      = 16,
   parameter int unsigned IN_FRAC_WIDTH = 8,
   parameter int unsigned OUT_MAN_WIDTH = 8,
   parameter int unsigned OUT_EXP_WIDTH = 4,
   parameter int unsigned BLOCK_SIZE    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [IN_WIDTH-1:0]      data_in,
   input  logic                     data_in_valid,
   output logic                     data_in_ready,
   output logic [OUT_MAN_WIDTH-1:0] mdata_out [BLOCK_SIZE-1:0],
   output logic [OUT_EXP_WIDTH-1:0] edata_out,
   output logic                     data_out_valid,
   input  logic                     data_out_ready
);

   localparam int unsigned CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int unsigned BW = $clog2(IN_WIDTH + 1);
   // wide enough for the largest left shift of a full-width input
   localparam int unsigned SW = IN_WIDTH + OUT_MAN_WIDTH + (2 ** (OUT_EXP_WIDTH - 1)) + IN_FRAC_WIDTH;
   localparam int EXP_MAX = (2 ** (OUT_EXP_WIDTH - 1)) - 1;
   localparam int EXP_MIN = -(2 ** (OUT_EXP_WIDTH - 1));
   localparam logic signed [SW-1:0] MAN_MAX = {{(SW - OUT_MAN_WIDTH + 1){1'b0}}, {(OUT_MAN_WIDTH - 1){1'b1}}};
   localparam logic signed [SW-1:0] MAN_MIN = ~MAN_MAX;

   logic [IN_WIDTH-1:0]      buf_q [BLOCK_SIZE];
   logic [CW-1:0]            count_q;
   logic                     buf_full_q;
   logic [BW-1:0]            bmax_q;
   logic [BW-1:0]            b_in;
   logic                     out_can_load;
   logic                     load;
   logic                     accept;
   int                       e_raw;
   int                       e_clamp;
   int                       shift;
   logic signed [SW-1:0]     wide;
   logic [OUT_MAN_WIDTH-1:0] man [BLOCK_SIZE];
   logic [OUT_EXP_WIDTH-1:0] exp_val;

   // bit length: smallest b with -2^b <= x < 2^b
   function automatic logic [BW-1:0] bit_len(input logic [IN_WIDTH-1:0] x);
      logic [IN_WIDTH-1:0] mag;
      bit_len = '0;
      mag = x[IN_WIDTH-1] ? ~x : x;
      for (int i = 0; i < int'(IN_WIDTH); i++) begin
         if (mag[i]) bit_len = BW'(i + 1);
      end
   endfunction

   // handshake qualifiers; input stalls only when a full buffer cannot move out
   always_comb begin
      out_can_load  = !data_out_valid || data_out_ready;
      load          = buf_full_q && out_can_load;
      data_in_ready = rst && (!buf_full_q || out_can_load);
      accept        = data_in_valid && data_in_ready;
      b_in          = bit_len(data_in);
   end

   // shared exponent and per-element normalisation of the collected block
   always_comb begin
      e_raw = int'(bmax_q) - int'(IN_FRAC_WIDTH);
      if (e_raw > EXP_MAX)      e_clamp = EXP_MAX;
      else if (e_raw < EXP_MIN) e_clamp = EXP_MIN;
      else                      e_clamp = e_raw;
      shift   = e_clamp + int'(IN_FRAC_WIDTH) - (int'(OUT_MAN_WIDTH) - 1);
      exp_val = OUT_EXP_WIDTH'(e_clamp);
      wide    = '0;
      for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
         wide = {{(SW - IN_WIDTH){buf_q[i][IN_WIDTH-1]}}, buf_q[i]};
         if (shift > 0) wide = wide >>> shift;
         else           wide = wide <<< (-shift);
         if (wide > MAN_MAX)      wide = MAN_MAX;
         else if (wide < MAN_MIN) wide = MAN_MIN;
         man[i] = wide[OUT_MAN_WIDTH-1:0];
      end
   end

   // element storage; contents are don't-care until the block completes
   always_ff @(posedge clk) begin
      if (accept) buf_q[count_q] <= data_in;
   end

   // collect-side control and output register
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q        <= '0;
         buf_full_q     <= 1'b0;
         bmax_q         <= '0;
         data_out_valid <= 1'b0;
         edata_out      <= '0;
         for (int i = 0; i < int'(BLOCK_SIZE); i++) mdata_out[i] <= '0;
      end else begin
         if (load) begin
            for (int i = 0; i < int'(BLOCK_SIZE); i++) mdata_out[i] <= man[i];
            edata_out      <= exp_val;
            data_out_valid <= 1'b1;
         end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
         end

         if (accept && (count_q == CW'(BLOCK_SIZE - 1))) buf_full_q <= 1'b1;
         else if (load)                                   buf_full_q <= 1'b0;

         if (accept) begin
            if (count_q == CW'(BLOCK_SIZE - 1)) count_q <= '0;
            else                                count_q <= count_q + CW'(1);
         end

         // an element accepted on the transfer edge starts the next block
         if (load)                        bmax_q <= accept ? b_in : '0;
         else if (accept && b_in > bmax_q) bmax_q <= b_in;
      end
   end

endmodule

// File: tb/tb_mxint_block_packer.sv
// Randomised and directed bench for mxint_block_packer with a queue scoreboard.
module tb_mxint_block_packer;

   localparam int BS = 4;
   localparam int PW = BS * 8 + 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] data_in = '0;
   logic        data_in_valid = 1'b0;
   logic        data_in_ready;
   logic [7:0]  mdata_out [3:0];
   logic [3:0]  edata_out;
   logic        data_out_valid;
   logic        data_out_ready = 1'b0;

   logic        ready_cmd = 1'b0;
   logic        rnd_ready = 1'b0;
   logic        drv_done = 1'b0;

   int          n_checks = 0;
   int          n_fail = 0;
   int          blocks_exp = 0;
   int          blocks_seen = 0;
   int          cur [$];
   logic [PW-1:0] exp_q [$];

   mxint_block_packer dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready), .mdata_out(mdata_out), .edata_out(edata_out),
      .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
   );

   always #5 clk = ~clk;

   // reference: integer arithmetic straight from the block format rules
   function automatic logic [PW-1:0] model_block(input int x0, input int x1, input int x2, input int x3);
      int xs [4];
      int bmax, b, e, s, m;
      logic [PW-1:0] r;
      xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
      bmax = 0;
      for (int i = 0; i < 4; i++) begin
         b = 0;
         while (!((xs[i] >= -(1 << b)) && (xs[i] < (1 << b)))) b++;
         if (b > bmax) bmax = b;
      end
      e = bmax - 8;
      if (e > 7) e = 7;
      if (e < -8) e = -8;
      s = e + 8 - 7;
      r = '0;
      r[3:0] = 4'(e);
      for (int i = 0; i < 4; i++) begin
         if (s > 0) m = xs[i] >>> s;
         else       m = xs[i] * (1 << (-s));
         if (m > 127)  m = 127;
         if (m < -128) m = -128;
         r[4 + 8*i +: 8] = 8'(m);
      end
      return r;
   endfunction

   function automatic logic [PW-1:0] dut_word();
      return {mdata_out[3], mdata_out[2], mdata_out[1], mdata_out[0], edata_out};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   task automatic model_accept(input int x);
      cur.push_back(x);
      if (cur.size() == BS) begin
         exp_q.push_back(model_block(cur[0], cur[1], cur[2], cur[3]));
         blocks_exp++;
         cur.delete();
      end
   endtask

   // offer one element; returns 1 ns after the accepting edge
   task automatic send(input int x);
      int waited;
      data_in = 16'(x);
      data_in_valid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!data_in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!data_in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: element %0d not accepted within 200 cycles", x);
         data_in_valid = 1'b0;
      end else begin
         @(posedge clk);
         model_accept(x);
         #1 data_in_valid = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int waited;
      ready_cmd = 1'b1;
      rnd_ready = 1'b0;
      waited = 0;
      while (exp_q.size() > 0 && waited < 300) begin
         @(posedge clk);
         waited++;
      end
      idle(3);
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      check("drain_valid_low", 64'(data_out_valid), 64'd0);
   endtask

   // data_out_ready is driven only here, 2 ns after each rising edge
   initial begin
      forever begin
         @(posedge clk);
         #2 data_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
      end
   end

   // monitor: pops expectations on output handshakes, checks stall stability
   initial begin
      logic [PW-1:0] held;
      logic          held_valid;
      logic [PW-1:0] want;
      held = '0;
      held_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            held_valid = 1'b0;
         end else begin
            if (held_valid) begin
               check("stall_valid_held", 64'(data_out_valid), 64'd1);
               check("stall_data_stable", 64'(dut_word()), 64'(held));
            end
            if (data_out_valid && data_out_ready) begin
               blocks_seen++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_block: got 0x%0h, expected no block", dut_word());
               end else begin
                  want = exp_q.pop_front();
                  check("block_data", 64'(dut_word()), 64'(want));
               end
               held_valid = 1'b0;
            end else if (data_out_valid) begin
               held = dut_word();
               held_valid = 1'b1;
            end else begin
               held_valid = 1'b0;
            end
         end
      end
   end

   // watchdog
   initial begin
      repeat (50000) @(posedge clk);
      if (!drv_done) begin
         $display("FAIL watchdog: got no completion, expected finish within 50000 cycles");
         $fatal(1, "watchdog expired");
      end
   end

   // driver
   initial begin
      int x;
      int xs [4];
      // reset state
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", 64'(data_out_valid), 64'd0);
      check("reset_edata", 64'(edata_out), 64'd0);
      check("reset_mdata", 64'(dut_word()), 64'd0);
      check("reset_in_ready_low", 64'(data_in_ready), 64'd0);
      rst = 1'b1;
      ready_cmd = 1'b1;
      idle(2);

      // block 1 with latency checks
      send(256); send(-128); send(64); send(0);
      check("lat_valid_at_k", 64'(data_out_valid), 64'd0);
      @(posedge clk);
      #1 check("lat_valid_at_k1", 64'(data_out_valid), 64'd1);
      idle(2);

      // directed blocks, back-to-back
      send(3); send(-1); send(2); send(1);
      send(0); send(0); send(0); send(0);
      send(32767); send(-32768); send(1); send(-1);
      idle(3);
      drain();

      // backpressure: 9 elements offered with the output stalled
      ready_cmd = 1'b0;
      idle(2);
      for (int i = 0; i < 8; i++) send(i * 37 - 100);
      data_in = 16'(1234);
      data_in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready_low", 64'(data_in_ready), 64'd0);
      end
      @(posedge clk);
      #1 ready_cmd = 1'b1;
      @(negedge clk);
      check("bp_in_ready_reenabled", 64'(data_in_ready), 64'd1);
      @(posedge clk);
      model_accept(1234);
      #1;
      data_in_valid = 1'b0;
      ready_cmd = 1'b0;
      check("bp_block2_valid", 64'(data_out_valid), 64'd1);
      idle(3);
      send(-5); send(77); send(-9000);
      idle(3);
      drain();

      // reset mid-block
      send(100); send(-200);
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready_low", 64'(data_in_ready), 64'd0);
      check("rst_valid_low", 64'(data_out_valid), 64'd0);
      @(posedge clk);
      #1;
      check("rst_valid_after", 64'(data_out_valid), 64'd0);
      rst = 1'b1;
      cur.delete();
      exp_q.delete();
      idle(1);
      send(256); send(-128); send(64); send(0);
      drain();

      // randomised traffic with random output backpressure
      rnd_ready = 1'b1;
      for (int n = 0; n < 60 * BS; n++) begin
         if ($urandom_range(0, 7) == 0) x = 0;
         else x = int'($signed(16'($urandom))) >>> $urandom_range(0, 15);
         send(x);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      drain();

      check("block_count", 64'(blocks_seen), 64'(blocks_exp));
      drv_done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
